// File: rtl/led_scan_reader.sv
// rtl/led_scan_reader.sv - page RAM scanner that streams bytes to an LED shifter
//
// Reads a run of pages from a registered-address page RAM, one byte at a time,
// and presents each byte on a valid/ready output. Each page is 4*BLK_NUM bytes
// addressed as {page[6:0], blk[3:0], lane[1:0]}; pages advance modulo 128.
//
// Ports:
//   rdclock     in   sole clock, also the page RAM read clock
//   rst_n       in   asynchronous active-low reset
//   start       in   one-cycle scan request (ignored while busy or page_cnt == 0)
//   page_base   in   first page index, sampled on an accepted start
//   page_cnt    in   number of pages to scan (1..128), sampled on an accepted start
//   abort       in   synchronous cancel, wins over start
//   rdaddress   out  registered page RAM read address
//   q           in   page RAM read data
//   out_data    out  byte to the downstream shifter
//   out_valid   out  out_data holds a byte
//   out_ready   in   downstream accepts the byte
//   busy        out  scan running or byte pending
//   row_done    out  pulse with the accepting cycle of the last byte of a page
//   frame_done  out  pulse with the accepting cycle of the last byte of the run
//
// Build option: define SCAN_BITREV_EN to bit-reverse every byte (q[0] -> out_data[7]).

module led_scan_reader #(
    parameter int BLK_NUM = 9
) (
    input  logic        rdclock,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  page_base,
    input  logic [7:0]  page_cnt,
    input  logic        abort,
    output logic [12:0] rdaddress,
    input  logic [7:0]  q,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        row_done,
    output logic        frame_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_CAPT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [3:0] LAST_BLK = 4'(BLK_NUM - 1);

    logic [1:0]  state_q, state_d;
    logic [12:0] addr_q, addr_d;
    logic [7:0]  cnt_q, cnt_d;         // pages left, including the current one
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        last_row_q, last_row_d;     // pending byte closes a page
    logic        last_frame_q, last_frame_d; // pending byte closes the run

    logic [6:0]  cur_page;
    logic [3:0]  cur_blk;
    logic [1:0]  cur_lane;
    logic        page_end;
    logic        frame_end;
    logic        xfer;
    logic        slot_free;
    logic [12:0] next_addr;
    logic [7:0]  capt_byte;

    assign cur_page  = addr_q[12:6];
    assign cur_blk   = addr_q[5:2];
    assign cur_lane  = addr_q[1:0];
    assign page_end  = (cur_blk == LAST_BLK) && (cur_lane == 2'd3);
    assign frame_end = page_end && (cnt_q == 8'd1);
    assign xfer      = valid_q && out_ready;

    // The output register can take a new byte at the end of CAPT if it is
    // empty now or is being emptied in this same cycle.
    assign slot_free = !valid_q || out_ready;

    // Inside a page blk never reaches 15 when lane rolls over, so a plain
    // increment of the low bits never carries into the page field.
    always_comb begin
        next_addr = addr_q + 13'd1;
        if (page_end) begin
            next_addr = {cur_page + 7'd1, 6'd0};
        end
    end

`ifdef SCAN_BITREV_EN
    always_comb begin
        capt_byte = '0;
        for (int i = 0; i < 8; i++) begin
            capt_byte[i] = q[7 - i];
        end
    end
`else
    assign capt_byte = q;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        valid_d      = valid_q;
        last_row_d   = last_row_q;
        last_frame_d = last_frame_q;

        if (xfer) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start && (page_cnt != 8'd0)) begin
                    cnt_d   = page_cnt;
                    addr_d  = {page_base, 6'd0};
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                // The RAM latches rdaddress at the end of this cycle; only
                // move on when the captured byte will have somewhere to go.
                if (slot_free) begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                data_d       = capt_byte;
                valid_d      = 1'b1;
                last_row_d   = page_end;
                last_frame_d = frame_end;
                if (frame_end) begin
                    state_d = S_HOLD;
                end else begin
                    // Next read overlaps with the byte now waiting on the output.
                    addr_d  = next_addr;
                    state_d = S_ADDR;
                    if (page_end) begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            S_HOLD: begin
                if (xfer) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge rdclock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            last_row_q   <= 1'b0;
            last_frame_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            last_row_q   <= last_row_d;
            last_frame_q <= last_frame_d;
        end
    end

    assign rdaddress = addr_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != S_IDLE);

    // Pulses mark the accepting cycle itself; an abort in that cycle
    // cancels the scan, so it also suppresses them.
    assign row_done   = xfer && last_row_q && !abort;
    assign frame_done = xfer && last_frame_q && !abort;

endmodule

// File: tb/tb_led_scan_reader.sv
// tb/tb_led_scan_reader.sv - randomized self-checking bench for led_scan_reader
module tb_led_scan_reader;

    localparam int BLK_NUM = 9;
    localparam int PB      = 4 * BLK_NUM;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  page_base;
    logic [7:0]  page_cnt;
    logic        abort;
    logic [12:0] rdaddress;
    logic [7:0]  q;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        row_done;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:8191];
    logic [12:0] ram_addr_q = '0;

    always #5 clk = ~clk;

    // Page RAM: address registered on the clock, data read combinationally.
    always @(posedge clk) ram_addr_q <= rdaddress;
    assign q = mem[ram_addr_q];

    led_scan_reader #(.BLK_NUM(BLK_NUM)) dut (
        .rdclock    (clk),
        .rst_n      (rst_n),
        .start      (start),
        .page_base  (page_base),
        .page_cnt   (page_cnt),
        .abort      (abort),
        .rdaddress  (rdaddress),
        .q          (q),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .row_done   (row_done),
        .frame_done (frame_done)
    );

    function automatic logic [7:0] model_byte(input int addr);
        logic [7:0] v;
        v = mem[addr];
`ifdef SCAN_BITREV_EN
        v = {<<{v}};
`endif
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdaddress"}, 32'(rdaddress), 0);
        chk({tag, "_out_data"}, 32'(out_data), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_row_done"}, 32'(row_done), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
    endtask

    // mode 0: out_ready always 1; mode 1: random out_ready plus ignored starts;
    // mode 2: out_ready held 0 for 10 cycles from the first valid byte.
    // abort_at >= 0 aborts in the cycle after that many transfers.
    task automatic run_scan(input logic [6:0] base, input int cnt, input int mode,
                            input int abort_at, input bit log_addr);
        logic [7:0]  exp_q[$];
        logic [12:0] addr_exp[$];
        logic [12:0] addr_log[$];
        int total, n, cyc, first_valid, last_xfer, stall_left, budget, a;

        for (int p = 0; p < cnt; p++) begin
            for (int b = 0; b < PB; b++) begin
                a = ((int'(base) + p) % 128) * 64 + b;
                addr_exp.push_back(13'(a));
                exp_q.push_back(model_byte(a));
            end
        end
        total = cnt * PB;

        @(negedge clk);
        start = 1'b1; page_base = base; page_cnt = 8'(cnt); out_ready = 1'b1; abort = 1'b0;
        @(negedge clk);
        start = 1'b0; page_base = 7'($urandom); page_cnt = 8'($urandom);
        chk("start_busy", 32'(busy), 1);
        chk("start_addr", 32'(rdaddress), 32'(addr_exp[0]));
        chk("start_valid", 32'(out_valid), 0);
        addr_log.push_back(rdaddress);

        n = 0; cyc = 0; first_valid = -1; last_xfer = 0; stall_left = 0;
        budget = total * 10 + 50;
        while (n < total && cyc < budget) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (log_addr && rdaddress !== addr_log[$]) addr_log.push_back(rdaddress);
            if (out_valid && first_valid < 0) begin
                first_valid = cyc;
                chk("first_latency", 32'(cyc), 2);
                if (mode == 2) stall_left = 10;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                chk("stall_data", 32'(out_data), 32'(exp_q[0]));
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_addr", 32'(rdaddress), 32'(addr_exp[1]));
            end else if (mode == 1) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
            if (mode == 1 && $urandom_range(0, 7) == 0) begin
                start = 1'b1; page_base = 7'($urandom); page_cnt = 8'($urandom_range(1, 128));
            end
            abort = (abort_at >= 0 && n == abort_at);
            #1;
            if (abort) begin
                chk("abort_row_done", 32'(row_done), 0);
                chk("abort_frame_done", 32'(frame_done), 0);
                @(negedge clk);
                abort = 1'b0;
                chk("abort_valid", 32'(out_valid), 0);
                chk("abort_busy", 32'(busy), 0);
                chk("abort_pulses", 32'({row_done, frame_done}), 0);
                return;
            end
            if (out_valid && out_ready) begin
                chk("data", 32'(out_data), 32'(exp_q[n]));
                chk("row_done", 32'(row_done), 32'((n % PB) == PB - 1));
                chk("frame_done", 32'(frame_done), 32'(n == total - 1));
                chk("busy", 32'(busy), 1);
                if (mode == 0 && n > 0) chk("xfer_gap", 32'(cyc - last_xfer), 2);
                last_xfer = cyc;
                n++;
            end else begin
                chk("idle_pulses", 32'({row_done, frame_done}), 0);
            end
        end
        chk("complete", 32'(n), 32'(total));

        @(negedge clk);
        start = 1'b0;
        chk("end_busy", 32'(busy), 0);
        chk("end_valid", 32'(out_valid), 0);
        chk("end_addr", 32'(rdaddress), 32'(addr_exp[total - 1]));
        if (log_addr) begin
            chk("addr_log_len", 32'(addr_log.size()), 32'(total));
            for (int i = 0; i < total && i < addr_log.size(); i++) begin
                chk("addr_seq", 32'(addr_log[i]), 32'(addr_exp[i]));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        page_base = '0; page_cnt = '0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        for (int i = 5 * 64; i < 7 * 64; i++) mem[i] = 8'(i);
        #1;
        chk_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // pages 5,6 hold their own address bytes: 0x40.. then 0x80..
        run_scan(7'd5, 2, 0, -1, 1'b1);
        // page wrap 127 -> 0
        run_scan(7'd127, 2, 0, -1, 1'b1);
        // downstream stall on the first byte
        run_scan(7'($urandom), 1, 2, -1, 1'b1);
        // random back-pressure and ignored starts
        for (int r = 0; r < 6; r++) begin
            run_scan(7'($urandom), $urandom_range(1, 3), 1, -1, 1'b0);
        end
        run_scan(7'd126, 3, 1, -1, 1'b0);
        // abort after the 10th transfer, then a fresh scan
        run_scan(7'($urandom), 2, 0, 10, 1'b0);
        run_scan(7'($urandom), 1, 0, -1, 1'b0);

        // abort beats start in the same cycle
        @(negedge clk);
        start = 1'b1; abort = 1'b1; page_base = 7'd3; page_cnt = 8'd1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_prio_busy", 32'(busy), 0);

        // page_cnt == 0 is ignored
        @(negedge clk);
        start = 1'b1; page_base = 7'd20; page_cnt = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("zero_cnt_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        chk("zero_cnt_busy_later", 32'(busy), 0);

        // reset in the middle of a page
        @(negedge clk);
        start = 1'b1; page_base = 7'd9; page_cnt = 8'd1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_scan(7'($urandom), 1, 1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
